// File: rtl/writeback.sv
`default_nettype none
// ============================================================================
//  Module   : writeback
//  Purpose  : Write-back stage of a sequential Y86-64 core. Derives the
//             destination registers (dstE/dstM) from the retiring
//             instruction, commits valE/valM into the 15-entry register file,
//             owns the architectural status machine (AOK/HLT/ADR/INS) and
//             counts retired instructions. Provides the two asynchronous
//             read ports used by decode.
//
//  Ports    :
//    clk          in   1     single clock, all state changes on rising edge
//    rst          in   1     synchronous reset, active-high
//    commit       in   1     present instruction retires this cycle
//    icode        in   4     Y86 instruction code (0 halt .. B popq)
//    cnd          in   1     condition result from execute (cmovXX)
//    rA, rB       in   4     register specifiers from fetch
//    valE         in   XLEN  ALU result
//    valM         in   XLEN  value read by the memory stage
//    instr_valid  in   1     0 = illegal icode detected in fetch
//    imem_error   in   1     instruction-fetch address fault
//    dmem_error   in   1     data-memory fault from the memory stage
//    srcA, srcB   in   4     decode read addresses
//    rdA, rdB     out  XLEN  register contents at srcA/srcB, 0 for index F
//    stat         out  3     1=AOK 2=HLT 3=ADR 4=INS
//    halted       out  1     high whenever stat != AOK
//    retired      out  64    instructions committed while AOK
//
//  Revision : 1.0  initial release
// ============================================================================
module writeback #(
    parameter int         XLEN    = 64,
    parameter int         NREGS   = 15,
    parameter logic [3:0] RSP_IDX = 4'd4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            commit,
    input  logic [3:0]      icode,
    input  logic            cnd,
    input  logic [3:0]      rA,
    input  logic [3:0]      rB,
    input  logic [XLEN-1:0] valE,
    input  logic [XLEN-1:0] valM,
    input  logic            instr_valid,
    input  logic            imem_error,
    input  logic            dmem_error,
    input  logic [3:0]      srcA,
    input  logic [3:0]      srcB,
    output logic [XLEN-1:0] rdA,
    output logic [XLEN-1:0] rdB,
    output logic [2:0]      stat,
    output logic            halted,
    output logic [63:0]     retired
);

    // Register index meaning "no register".
    localparam logic [3:0] c_RNONE = 4'hF;

    // Instruction codes that matter for destination selection.
    localparam logic [3:0] c_IHALT   = 4'h0;
    localparam logic [3:0] c_IRRMOVQ = 4'h2;
    localparam logic [3:0] c_IIRMOVQ = 4'h3;
    localparam logic [3:0] c_IMRMOVQ = 4'h5;
    localparam logic [3:0] c_IOPQ    = 4'h6;
    localparam logic [3:0] c_ICALL   = 4'h8;
    localparam logic [3:0] c_IRET    = 4'h9;
    localparam logic [3:0] c_IPUSHQ  = 4'hA;
    localparam logic [3:0] c_IPOPQ   = 4'hB;

    // State encodings double as the externally visible status codes.
    typedef enum logic [2:0] {
        ST_AOK = 3'd1,
        ST_HLT = 3'd2,
        ST_ADR = 3'd3,
        ST_INS = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [XLEN-1:0]   r_regs [NREGS];
    logic [63:0]       r_retired;

    logic [3:0]        w_dstE;
    logic [3:0]        w_dstM;
    logic              w_addr_fault;
    logic              w_fault;
    logic              w_take;
    logic              w_we;

    // ------------------------------------------------------------------
    // Destination selection
    // ------------------------------------------------------------------
    always_comb begin
        w_dstE = c_RNONE;
        unique case (icode)
            c_IRRMOVQ: w_dstE = cnd ? rB : c_RNONE;   // cmovXX not taken writes nothing
            c_IIRMOVQ,
            c_IOPQ:    w_dstE = rB;
            c_ICALL,
            c_IRET,
            c_IPUSHQ,
            c_IPOPQ:   w_dstE = RSP_IDX;
            default:   w_dstE = c_RNONE;
        endcase
    end

    always_comb begin
        w_dstM = c_RNONE;
        if (icode == c_IMRMOVQ || icode == c_IPOPQ) begin
            w_dstM = rA;
        end
    end

    // ------------------------------------------------------------------
    // Retirement qualification
    // ------------------------------------------------------------------
    // Only a commit seen while AOK can do anything; once the machine has
    // stopped, every later commit is ignored until reset.
    assign w_take       = commit && (r_state == ST_AOK);
    assign w_addr_fault = imem_error || dmem_error;
    assign w_fault      = w_addr_fault || !instr_valid;
    // A faulting instruction neither writes nor counts. A halt instruction
    // has no destinations, so it writes nothing but still counts.
    assign w_we         = w_take && !w_fault;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    // The dstM assignment is placed last so that it overrides dstE when both
    // name the same register (popq %rsp keeps the popped value).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            if (w_dstE != c_RNONE) begin
                r_regs[w_dstE] <= valE;
            end
            if (w_dstM != c_RNONE) begin
                r_regs[w_dstM] <= valM;
            end
        end
    end

    // Asynchronous reads with no write bypass: a write on this edge becomes
    // visible only after the edge.
    assign rdA = (srcA == c_RNONE) ? '0 : r_regs[srcA];
    assign rdB = (srcB == c_RNONE) ? '0 : r_regs[srcB];

    // ------------------------------------------------------------------
    // Status machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_AOK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Fault priority: address fault, then illegal instruction, then halt.
    always_comb begin
        w_state_next = r_state;
        if (w_take) begin
            if (w_addr_fault) begin
                w_state_next = ST_ADR;
            end else if (!instr_valid) begin
                w_state_next = ST_INS;
            end else if (icode == c_IHALT) begin
                w_state_next = ST_HLT;
            end
        end
    end

    assign stat   = r_state;
    assign halted = (r_state != ST_AOK);

    // ------------------------------------------------------------------
    // Retired-instruction counter (wraps silently at 2^64)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_we) begin
            r_retired <= r_retired + 64'd1;
        end
    end

    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : tb_writeback
//  Purpose  : Directed bench for writeback. Each stimulus step drives one
//             cycle of inputs just after a rising edge and queues the values
//             the outputs must show before the next rising edge. A separate
//             monitor drains the queue on every falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_writeback;

    localparam logic [3:0] c_F = 4'hF;

    logic        clk;
    logic        rst;
    logic        commit;
    logic [3:0]  icode;
    logic        cnd;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        instr_valid;
    logic        imem_error;
    logic        dmem_error;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] rdA;
    logic [63:0] rdB;
    logic [2:0]  stat;
    logic        halted;
    logic [63:0] retired;

    writeback #(
        .XLEN    (64),
        .NREGS   (15),
        .RSP_IDX (4'd4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .commit      (commit),
        .icode       (icode),
        .cnd         (cnd),
        .rA          (rA),
        .rB          (rB),
        .valE        (valE),
        .valM        (valM),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .dmem_error  (dmem_error),
        .srcA        (srcA),
        .srcB        (srcB),
        .rdA         (rdA),
        .rdB         (rdB),
        .stat        (stat),
        .halted      (halted),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] rda;
        logic [63:0] rdb;
        logic [2:0]  st;
        logic [63:0] ret;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string nm, input string fld,
                       input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s.%s got=0x%0h expected=0x%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: everything queued since the last rising edge is checked here.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "rdA",     rdA,           e.rda);
            chk(e.name, "rdB",     rdB,           e.rdb);
            chk(e.name, "stat",    {61'd0, stat}, {61'd0, e.st});
            chk(e.name, "halted",  {63'd0, halted}, {63'd0, (e.st != 3'd1)});
            chk(e.name, "retired", retired,       e.ret);
        end
    end

    // One cycle: drive inputs after the edge, queue the expected outputs
    // for the sample point before the next edge.
    task automatic step(
        input logic        r,  input logic        cm, input logic [3:0] ic,
        input logic        cd, input logic [3:0]  a,  input logic [3:0] b,
        input logic [63:0] ve, input logic [63:0] vm,
        input logic        iv, input logic        ie, input logic       de,
        input logic [3:0]  sa, input logic [3:0]  sb,
        input string       nm,
        input logic [63:0] ea, input logic [63:0] eb,
        input logic [2:0]  es, input logic [63:0] er);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; commit = cm; icode = ic; cnd = cd; rA = a; rB = b;
        valE = ve; valM = vm; instr_valid = iv; imem_error = ie;
        dmem_error = de; srcA = sa; srcB = sb;
        e.name = nm; e.rda = ea; e.rdb = eb; e.st = es; e.ret = er;
        exp_q.push_back(e);
    endtask

    // Idle cycle: no commit, just read two registers.
    task automatic idle(input logic r, input logic [3:0] sa, input logic [3:0] sb,
                        input string nm, input logic [63:0] ea,
                        input logic [63:0] eb, input logic [2:0] es,
                        input logic [63:0] er);
        step(r, 1'b0, 4'h1, 1'b0, c_F, c_F, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0,
             sa, sb, nm, ea, eb, es, er);
    endtask

    initial begin
        rst = 1'b1; commit = 1'b0; icode = 4'h1; cnd = 1'b0; rA = c_F; rB = c_F;
        valE = '0; valM = '0; instr_valid = 1'b1; imem_error = 1'b0;
        dmem_error = 1'b0; srcA = c_F; srcB = c_F;
        repeat (2) @(posedge clk);

        //    rst  cm  icode cnd rA   rB   valE        valM       iv  ie  de  srcA srcB  name              rdA         rdB         st   ret
        idle(1'b0, 4'd0, c_F, "reset", 64'd0, 64'd0, 3'd1, 64'd0);
        step(1'b0,1'b1,4'h3,1'b0,c_F, 4'd2,64'h2A,     64'd0,     1'b1,1'b0,1'b0,4'd2,c_F, "irmov_pre",  64'd0,      64'd0,      3'd1,64'd0);
        idle(1'b0, 4'd2, 4'd3, "irmov_post", 64'h2A, 64'd0, 3'd1, 64'd1);
        step(1'b0,1'b1,4'h2,1'b0,4'd2,4'd3,64'd5,      64'd0,     1'b1,1'b0,1'b0,4'd3,4'd2,"cmov_nt_pre",64'd0,      64'h2A,     3'd1,64'd1);
        idle(1'b0, 4'd3, 4'd2, "cmov_nt_post", 64'd0, 64'h2A, 3'd1, 64'd2);
        step(1'b0,1'b1,4'h2,1'b1,4'd2,4'd3,64'd5,      64'd0,     1'b1,1'b0,1'b0,4'd3,c_F, "cmov_t_pre", 64'd0,      64'd0,      3'd1,64'd2);
        idle(1'b0, 4'd3, c_F, "cmov_t_post", 64'd5, 64'd0, 3'd1, 64'd3);
        step(1'b0,1'b1,4'hB,1'b0,4'd4,c_F, 64'h108,    64'h77,    1'b1,1'b0,1'b0,4'd4,c_F, "popq_pre",   64'd0,      64'd0,      3'd1,64'd3);
        idle(1'b0, 4'd4, c_F, "popq_rsp", 64'h77, 64'd0, 3'd1, 64'd4);
        step(1'b0,1'b1,4'hA,1'b0,4'd2,c_F, 64'h100,    64'd0,     1'b1,1'b0,1'b0,4'd4,c_F, "pushq_pre",  64'h77,     64'd0,      3'd1,64'd4);
        idle(1'b0, 4'd4, c_F, "pushq_post", 64'h100, 64'd0, 3'd1, 64'd5);
        step(1'b0,1'b1,4'h3,1'b0,c_F, 4'd5,64'h10,     64'd0,     1'b1,1'b0,1'b0,4'd5,c_F, "rw_same_old",64'd0,      64'd0,      3'd1,64'd5);
        idle(1'b0, 4'd5, c_F, "rw_same_new", 64'h10, 64'd0, 3'd1, 64'd6);
        step(1'b0,1'b1,4'h5,1'b0,4'd1,c_F, 64'd0,      64'd9,     1'b1,1'b0,1'b1,4'd1,c_F, "mrmov_f_pre",64'd0,      64'd0,      3'd1,64'd6);
        step(1'b0,1'b1,4'h3,1'b0,c_F, 4'd1,64'h55,     64'd0,     1'b1,1'b0,1'b0,4'd1,c_F, "adr_state",  64'd0,      64'd0,      3'd3,64'd6);
        idle(1'b0, 4'd1, 4'd2, "adr_frozen", 64'd0, 64'h2A, 3'd3, 64'd6);
        idle(1'b1, 4'd2, c_F, "adr_pre_rst", 64'h2A, 64'd0, 3'd3, 64'd6);
        idle(1'b0, 4'd2, 4'd4, "reset_clear", 64'd0, 64'd0, 3'd1, 64'd0);

        // Halt, then reset in the halted state while a commit is presented.
        step(1'b0,1'b1,4'h3,1'b0,c_F, 4'd0,64'h11,     64'd0,     1'b1,1'b0,1'b0,4'd0,c_F, "r0_pre",     64'd0,      64'd0,      3'd1,64'd0);
        step(1'b0,1'b1,4'h0,1'b0,c_F, c_F, 64'd0,      64'd0,     1'b1,1'b0,1'b0,4'd0,c_F, "halt_pre",   64'h11,     64'd0,      3'd1,64'd1);
        step(1'b0,1'b1,4'h3,1'b0,c_F, 4'd6,64'h66,     64'd0,     1'b1,1'b0,1'b0,4'd0,4'd6,"hlt_state",  64'h11,     64'd0,      3'd2,64'd2);
        idle(1'b0, 4'd0, 4'd6, "hlt_frozen", 64'h11, 64'd0, 3'd2, 64'd2);
        step(1'b1,1'b1,4'h3,1'b0,c_F, 4'd6,64'h99,     64'd0,     1'b1,1'b0,1'b0,4'd0,4'd6,"hlt_rst_pre",64'h11,     64'd0,      3'd2,64'd2);
        idle(1'b0, 4'd0, 4'd6, "rst_mid_hlt", 64'd0, 64'd0, 3'd1, 64'd0);

        // ADR wins over INS when both are flagged.
        step(1'b0,1'b1,4'h5,1'b0,4'd1,c_F, 64'd0,      64'd3,     1'b0,1'b0,1'b1,4'd1,c_F, "prio_pre",   64'd0,      64'd0,      3'd1,64'd0);
        idle(1'b0, 4'd1, c_F, "adr_over_ins", 64'd0, 64'd0, 3'd3, 64'd0);
        idle(1'b1, 4'd1, c_F, "prio_rst", 64'd0, 64'd0, 3'd3, 64'd0);
        step(1'b0,1'b1,4'h3,1'b0,c_F, 4'd7,64'd7,      64'd0,     1'b0,1'b0,1'b0,4'd7,c_F, "ins_pre",    64'd0,      64'd0,      3'd1,64'd0);
        idle(1'b0, 4'd7, c_F, "ins_state", 64'd0, 64'd0, 3'd4, 64'd0);
        idle(1'b1, 4'd7, c_F, "ins_rst", 64'd0, 64'd0, 3'd4, 64'd0);

        // commit=0 with otherwise active inputs must change nothing.
        step(1'b0,1'b0,4'h3,1'b0,c_F, 4'd2,64'hDEAD,   64'd0,     1'b1,1'b0,1'b1,4'd2,c_F, "nocommit_pre",64'd0,     64'd0,      3'd1,64'd0);
        idle(1'b0, 4'd2, c_F, "nocommit", 64'd0, 64'd0, 3'd1, 64'd0);
        // popq with rA=F: only %rsp is updated.
        step(1'b0,1'b1,4'hB,1'b0,c_F, c_F, 64'h8,      64'd5,     1'b1,1'b0,1'b0,4'd4,c_F, "popq_rf_pre",64'd0,      64'd0,      3'd1,64'd0);
        idle(1'b0, 4'd4, c_F, "popq_rf", 64'h8, 64'd0, 3'd1, 64'd1);
        // Instruction-fetch fault.
        step(1'b0,1'b1,4'h3,1'b0,c_F, 4'd2,64'd1,      64'd0,     1'b1,1'b1,1'b0,4'd2,4'd4,"imem_pre",   64'd0,      64'h8,      3'd1,64'd1);
        idle(1'b0, 4'd2, 4'd4, "imem_err", 64'd0, 64'h8, 3'd3, 64'd1);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain queued=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached=100000ns expected=finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
